// File: rtl/audioport_pkg.sv
// -----------------------------------------------------------------------------
// audioport_pkg
// Shared types and default constants for the audio port blocks.
//   i2s_state_t    : I2S transmitter control state (IDLE, RUN, STOP)
//   I2S_SCK_DIV    : default clk cycles per serial bit clock period
//   I2S_SLOT_BITS  : default sck periods per channel slot
//   I2S_DATA_BITS  : default sample width
// -----------------------------------------------------------------------------
package audioport_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      STOP = 2'd2
   } i2s_state_t;

   localparam int I2S_SCK_DIV   = 4;
   localparam int I2S_SLOT_BITS = 32;
   localparam int I2S_DATA_BITS = 24;

endpackage

// File: rtl/i2s_unit.sv
// -----------------------------------------------------------------------------
// i2s_unit
// Philips I2S serial transmitter (1-bit delay, MSB first) in the mclk domain.
// A sample buffer is loaded on tick_in; at the first cycle of every frame the
// buffer is copied into a frame-wide shift register and req_out pulses once to
// ask for the next sample.
// Ports:
//   clk        : mclk-domain clock
//   rst        : synchronous, active-high reset
//   play_in    : 1 = run frames, 0 = stop after the current frame
//   tick_in    : 1-cycle strobe, audio0_in/audio1_in valid
//   audio0_in  : left sample, two's complement
//   audio1_in  : right sample, two's complement
//   req_out    : 1-cycle pulse at frame start (buffer consumed)
//   sck_out    : serial bit clock to the DAC
//   ws_out     : word select, 0 = left, 1 = right
//   sdo_out    : serial data to the DAC
// -----------------------------------------------------------------------------
module i2s_unit
   import audioport_pkg::*;
#(
   parameter int SCK_DIV   = I2S_SCK_DIV,
   parameter int SLOT_BITS = I2S_SLOT_BITS,
   parameter int DATA_BITS = I2S_DATA_BITS
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 play_in,
   input  logic                 tick_in,
   input  logic [DATA_BITS-1:0] audio0_in,
   input  logic [DATA_BITS-1:0] audio1_in,
   output logic                 req_out,
   output logic                 sck_out,
   output logic                 ws_out,
   output logic                 sdo_out
);

   localparam int FRAME_BITS = 2 * SLOT_BITS;
   localparam int CTR_W      = $clog2(SCK_DIV);
   localparam int BIT_W      = $clog2(FRAME_BITS);

   localparam logic [CTR_W-1:0] CTR_LAST = CTR_W'(SCK_DIV - 1);
   localparam logic [CTR_W-1:0] CTR_HALF = CTR_W'(SCK_DIV / 2);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);
   localparam logic [BIT_W-1:0] WS_FIRST = BIT_W'(SLOT_BITS - 1);
   localparam logic [BIT_W-1:0] WS_LAST  = BIT_W'(FRAME_BITS - 2);

   i2s_state_t                  state_r;
   i2s_state_t                  state_nxt;
   logic                        load_frame;
   logic                        frame_end;
   logic                        running;
   logic [CTR_W-1:0]            ctr_r;
   logic [BIT_W-1:0]            bit_r;
   logic [FRAME_BITS-1:0]       shreg_r;
   logic signed [DATA_BITS-1:0] buf_l_r;
   logic signed [DATA_BITS-1:0] buf_r_r;

   // One channel slot: leading 0 (the I2S 1-bit delay), sample MSB first,
   // zero padding to the end of the slot.
   function automatic logic [SLOT_BITS-1:0] slot_word(input logic signed [DATA_BITS-1:0] d);
      logic [SLOT_BITS-1:0] w;
      w = '0;
      w[SLOT_BITS-2 -: DATA_BITS] = d;
      return w;
   endfunction

   assign frame_end = (ctr_r == CTR_LAST) && (bit_r == BIT_LAST);

   always_comb begin
      state_nxt  = state_r;
      load_frame = 1'b0;
      case (state_r)
         IDLE: begin
            if (play_in) begin
               state_nxt  = RUN;
               load_frame = 1'b1;
            end
         end
         RUN: begin
            if (frame_end) begin
               if (play_in) begin
                  load_frame = 1'b1;
               end else begin
                  state_nxt = IDLE;
               end
            end else if (!play_in) begin
               state_nxt = STOP;
            end
         end
         STOP: begin
            // play_in is deliberately ignored here; restart goes through IDLE.
            if (frame_end) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
         ctr_r   <= '0;
         bit_r   <= '0;
         shreg_r <= '0;
         buf_l_r <= '0;
         buf_r_r <= '0;
      end else begin
         state_r <= state_nxt;
         // On a tick coincident with a frame load the shift register still
         // takes the old buffer contents (non-blocking read of buf_*_r).
         if (tick_in) begin
            buf_l_r <= audio0_in;
            buf_r_r <= audio1_in;
         end
         if (load_frame) begin
            shreg_r <= {slot_word(buf_l_r), slot_word(buf_r_r)};
            ctr_r   <= '0;
            bit_r   <= '0;
         end else if (state_r != IDLE) begin
            if (ctr_r == CTR_LAST) begin
               ctr_r   <= '0;
               shreg_r <= shreg_r << 1;
               bit_r   <= (bit_r == BIT_LAST) ? '0 : bit_r + 1'b1;
            end else begin
               ctr_r <= ctr_r + 1'b1;
            end
         end
      end
   end

   always_comb begin
      running = (state_r != IDLE);
      req_out = running && (ctr_r == '0) && (bit_r == '0);
      sck_out = running && (ctr_r >= CTR_HALF);
      ws_out  = running && (bit_r >= WS_FIRST) && (bit_r <= WS_LAST);
      sdo_out = running && shreg_r[FRAME_BITS-1];
   end

endmodule

// File: tb/tb_i2s_unit.sv
// -----------------------------------------------------------------------------
// tb_i2s_unit
// Self-checking bench for i2s_unit. A frame-level reference model counts clk
// cycles within a frame and, at each frame start, queues the 64 expected
// (ws, sdo) pairs computed from the sample it holds; a monitor pops one entry
// per sck rising edge and also checks req_out/sck_out every cycle.
// -----------------------------------------------------------------------------
module tb_i2s_unit;

   localparam int SCK_DIV    = 4;
   localparam int SLOT_BITS  = 32;
   localparam int DATA_BITS  = 24;
   localparam int FRAME_BITS = 2 * SLOT_BITS;
   localparam int FRAME_CLK  = FRAME_BITS * SCK_DIV;

   logic                 clk;
   logic                 rst;
   logic                 play_in;
   logic                 tick_in;
   logic [DATA_BITS-1:0] audio0_in;
   logic [DATA_BITS-1:0] audio1_in;
   logic                 req_out;
   logic                 sck_out;
   logic                 ws_out;
   logic                 sdo_out;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int   k;
      logic ws;
      logic sdo;
   } exp_bit_t;

   exp_bit_t exp_q[$];

   // model state
   int                   p = -1;        // clk index within the frame, -1 = idle
   logic                 stopping = 1'b0;
   logic [DATA_BITS-1:0] mbuf_l = '0;
   logic [DATA_BITS-1:0] mbuf_r = '0;
   logic                 sck_prev = 1'b0;

   i2s_unit #(
      .SCK_DIV  (SCK_DIV),
      .SLOT_BITS(SLOT_BITS),
      .DATA_BITS(DATA_BITS)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .play_in  (play_in),
      .tick_in  (tick_in),
      .audio0_in(audio0_in),
      .audio1_in(audio1_in),
      .req_out  (req_out),
      .sck_out  (sck_out),
      .ws_out   (ws_out),
      .sdo_out  (sdo_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic start_frame();
      exp_bit_t e;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL frame_leftover: %0d bits still unsent, required 0", exp_q.size());
         exp_q.delete();
      end
      p = 0;
      for (int k = 0; k < FRAME_BITS; k++) begin
         e.k   = k;
         e.ws  = (k >= SLOT_BITS - 1) && (k <= FRAME_BITS - 2);
         e.sdo = 1'b0;
         if (k >= 1 && k <= DATA_BITS)
            e.sdo = mbuf_l[DATA_BITS - k];
         else if (k >= SLOT_BITS + 1 && k <= SLOT_BITS + DATA_BITS)
            e.sdo = mbuf_r[DATA_BITS - (k - SLOT_BITS)];
         exp_q.push_back(e);
      end
   endtask

   // Reference model: advances on the same clock edge the DUT samples inputs.
   always @(posedge clk) begin
      if (rst) begin
         p        = -1;
         stopping = 1'b0;
         mbuf_l   = '0;
         mbuf_r   = '0;
         exp_q.delete();
      end else begin
         if (p < 0) begin
            if (play_in) start_frame();
         end else if (p == FRAME_CLK - 1) begin
            if (!stopping && play_in) begin
               start_frame();
            end else begin
               p        = -1;
               stopping = 1'b0;
            end
         end else begin
            p++;
            if (!play_in) stopping = 1'b1;
         end
         if (tick_in) begin
            mbuf_l = audio0_in;
            mbuf_r = audio1_in;
         end
      end
   end

   // Monitor: compares on the falling edge, away from the DUT's active edge.
   always @(negedge clk) begin
      logic     exp_sck;
      exp_bit_t e;
      exp_sck = (p >= 0) && ((p % SCK_DIV) >= SCK_DIV / 2);
      checks++;
      if (req_out !== (p == 0)) begin
         errors++;
         $display("FAIL req_out: p=%0d got %b, required %b", p, req_out, (p == 0));
      end
      checks++;
      if (sck_out !== exp_sck) begin
         errors++;
         $display("FAIL sck_out: p=%0d got %b, required %b", p, sck_out, exp_sck);
      end
      if (p < 0) begin
         checks++;
         if (ws_out !== 1'b0 || sdo_out !== 1'b0) begin
            errors++;
            $display("FAIL idle_outputs: ws=%b sdo=%b, required 0 0", ws_out, sdo_out);
         end
      end
      if (sck_out && !sck_prev) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sck_rise_unexpected: sck rose with no expected bit, p=%0d", p);
         end else begin
            e = exp_q.pop_front();
            if (ws_out !== e.ws || sdo_out !== e.sdo) begin
               errors++;
               $display("FAIL bit%0d: ws=%b sdo=%b, required ws=%b sdo=%b",
                        e.k, ws_out, sdo_out, e.ws, e.sdo);
            end
         end
      end
      sck_prev = sck_out;
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_tick(input logic [DATA_BITS-1:0] l, input logic [DATA_BITS-1:0] r);
      tick_in   = 1'b1;
      audio0_in = l;
      audio1_in = r;
      step(1);
      tick_in = 1'b0;
   endtask

   initial begin
      rst       = 1'b1;
      play_in   = 1'b1;
      tick_in   = 1'b0;
      audio0_in = '0;
      audio1_in = '0;
      step(2);
      rst     = 1'b0;
      play_in = 1'b0;
      step(3);

      // directed frame, then stop requested at bit 10 of the third frame
      do_tick(24'h800001, 24'h7FFFFE);
      play_in = 1'b1;
      step(2 * FRAME_CLK + 10 * SCK_DIV + 1);
      play_in = 1'b0;
      step(100);
      play_in = 1'b1;               // ignored while stopping
      step(200);
      play_in = 1'b0;
      step(FRAME_CLK + 20);

      // collision: tick B on the frame-load edge while the buffer holds A
      do_tick(24'h123456, 24'hABCDEF);
      play_in   = 1'b1;
      tick_in   = 1'b1;
      audio0_in = 24'h0F0F0F;
      audio1_in = 24'hF0F0F0;
      step(1);
      tick_in = 1'b0;
      // underrun: no further ticks for several frames
      step(4 * FRAME_CLK);
      play_in = 1'b0;
      step(FRAME_CLK + 20);

      // reset at bit 40, released with play held high
      do_tick(24'h5A5A5A, 24'hA5A5A5);
      play_in = 1'b1;
      step(40 * SCK_DIV + 1);
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      step(FRAME_CLK + 30);

      // randomized traffic
      for (int i = 0; i < 30; i++) begin
         int act;
         act = $urandom_range(0, 19);
         if (act < 12) begin
            do_tick(DATA_BITS'($urandom), DATA_BITS'($urandom));
         end else if (act < 17) begin
            play_in = ~play_in;
         end else if (act == 17) begin
            rst = 1'b1;
            step(1);
            rst = 1'b0;
         end
         step($urandom_range(1, 120));
      end

      // drain: stop and wait (bounded) for the model to return to idle
      play_in = 1'b0;
      step(FRAME_CLK + 20);
      checks++;
      if (p >= 0 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: p=%0d pending=%0d, required idle with 0 pending", p, exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
